// File: rtl/psimd_issue_pkg.sv
// Shared types and constants for the PSIMD instruction issuer.
package psimd_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } issuer_state_e;

  // One exception bit per SIMD lane.
  localparam int FLAG_W = 4;

  // All-zero word decodes on the core with wr_enable=0.
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/psimd_instr_buf.sv
// Program buffer for the PSIMD issuer: DEPTH x INSTR_W slots, appended in
// order by the host, read asynchronously by the issuer's pointer.
module psimd_instr_buf #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     wr_en_i,
  input  logic [INSTR_W-1:0]       wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr_i,
  output logic [INSTR_W-1:0]       rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [PTR_W-1:0]   wr_ptr;
  logic               wr_fire;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign wr_fire = wr_en_i && !full_o && !clear_i;
  assign wr_ptr  = count_q[PTR_W-1:0];

  // Next word count: clear empties the buffer, an accepted write appends.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (wr_fire) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Word count register; it doubles as the write pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is not reset; only slots below the count are ever read.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_i];
  assign count_o   = count_q;

endmodule

// File: rtl/psimd_instr_issuer.sv
// PSIMD instruction issuer: streams a host-loaded program onto the core's
// instr input with an optional NOP gap after each word, and gathers the
// core's per-lane exception flags into sticky accumulators.
// Optional build macro PSIMD_ISSUE_PERF_EN adds the perf_cycles counter.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting; host may load words
// ST_ISSUE | driving slot[ptr] with instr_valid=1
// ST_GAP   | driving NOP between words, gap counter running
// ST_DONE  | program finished; done held, host may load or restart
module psimd_instr_issuer
  import psimd_issue_pkg::*;
#(
  parameter int                 DEPTH     = 16,
  parameter int                 INSTR_W   = 32,
  parameter int                 GAP_W     = 3,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [INSTR_W-1:0]     load_data,
  input  logic                   start,
  input  logic                   clear,
  input  logic [GAP_W-1:0]       gap_cycles,
  output logic [INSTR_W-1:0]     instr,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] prog_count,
  input  logic [FLAG_W-1:0]      invalid,
  input  logic [FLAG_W-1:0]      inexact,
  input  logic [FLAG_W-1:0]      overflow,
  input  logic [FLAG_W-1:0]      underflow,
  input  logic [FLAG_W-1:0]      div_by_zero,
`ifdef PSIMD_ISSUE_PERF_EN
  output logic [15:0]            perf_cycles,
`endif
  output logic [FLAG_W-1:0]      invalid_acc,
  output logic [FLAG_W-1:0]      inexact_acc,
  output logic [FLAG_W-1:0]      overflow_acc,
  output logic [FLAG_W-1:0]      underflow_acc,
  output logic [FLAG_W-1:0]      div_by_zero_acc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  issuer_state_e      state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [GAP_W-1:0]   gap_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               done_q;
  logic [FLAG_W-1:0]  invalid_q;
  logic [FLAG_W-1:0]  inexact_q;
  logic [FLAG_W-1:0]  overflow_q;
  logic [FLAG_W-1:0]  underflow_q;
  logic [FLAG_W-1:0]  div_by_zero_q;

  logic [INSTR_W-1:0] rd_data;
  logic [CNT_W-1:0]   count;
  logic               buf_full;
  logic               idle_like;
  logic               load_fire;
  logic               start_fire;
  logic               last_word;

  assign idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign load_ready = idle_like && !buf_full;
  assign load_fire  = load_valid && load_ready && !clear;
  assign start_fire = start && idle_like && !clear;
  assign last_word  = (({1'b0, ptr_q} + CNT_W'(1)) == count);

  psimd_instr_buf #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear),
    .wr_en_i   (load_fire),
    .wr_data_i (load_data),
    .rd_ptr_i  (ptr_q),
    .rd_data_o (rd_data),
    .count_o   (count),
    .full_o    (buf_full)
  );

  // Issue sequencer: state, read pointer, gap counter, done and flag accumulators.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      gap_q         <= '0;
      gap_cnt_q     <= '0;
      done_q        <= 1'b0;
      invalid_q     <= '0;
      inexact_q     <= '0;
      overflow_q    <= '0;
      underflow_q   <= '0;
      div_by_zero_q <= '0;
    end else if (clear) begin
      // Accumulators survive a clear so the host can still read them.
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE) begin
        invalid_q     <= invalid_q     | invalid;
        inexact_q     <= inexact_q     | inexact;
        overflow_q    <= overflow_q    | overflow;
        underflow_q   <= underflow_q   | underflow;
        div_by_zero_q <= div_by_zero_q | div_by_zero;
      end
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (load_fire) begin
            done_q <= 1'b0;
          end
          if (start_fire) begin
            if (count == '0) begin
              // Empty program: finish immediately, accumulators untouched.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q       <= ST_ISSUE;
              ptr_q         <= '0;
              gap_q         <= gap_cycles;
              done_q        <= 1'b0;
              invalid_q     <= '0;
              inexact_q     <= '0;
              overflow_q    <= '0;
              underflow_q   <= '0;
              div_by_zero_q <= '0;
            end
          end
        end
        ST_ISSUE: begin
          ptr_q <= ptr_q + PTR_W'(1);
          if (last_word) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (gap_q != '0) begin
            state_q   <= ST_GAP;
            gap_cnt_q <= gap_q;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q <= GAP_W'(1)) begin
            state_q <= ST_ISSUE;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PSIMD_ISSUE_PERF_EN
  logic [15:0] perf_q;

  // Counts ISSUE+GAP cycles of the current run, saturating; frozen in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (start_fire) begin
      perf_q <= '0;
    end else if (((state_q == ST_ISSUE) || (state_q == ST_GAP)) && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

  assign instr           = (state_q == ST_ISSUE) ? rd_data : NOP_INSTR;
  assign instr_valid     = (state_q == ST_ISSUE);
  assign busy            = (state_q == ST_ISSUE) || (state_q == ST_GAP);
  assign done            = done_q;
  assign prog_count      = count;
  assign invalid_acc     = invalid_q;
  assign inexact_acc     = inexact_q;
  assign overflow_acc    = overflow_q;
  assign underflow_acc   = underflow_q;
  assign div_by_zero_acc = div_by_zero_q;

endmodule

// File: doc/psimd_instr_issuer.md
Name: psimd_instr_issuer

Overview:
Instruction-side driver for the PSIMD core. A host loads a short program of 32-bit PSIMD instructions into a local buffer. On start, the block streams them onto the core's instr input, one per cycle, with an optional NOP gap after each. While issuing, it collects the core's per-lane exception flags into sticky summary registers and raises done at program end.

Parameters:
DEPTH, 16, number of instruction slots (power of 2, >=2)
INSTR_W, 32, instruction width
GAP_W, 3, width of the gap_cycles configuration input
NOP_INSTR, 32'h0000_0000, word driven on instr when not issuing (core decodes it with wr_enable=0)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
load_valid  input  1  host offers load_data
load_ready  output  1  buffer accepts a word this cycle
load_data  input  INSTR_W  instruction word to append
start  input  1  one-cycle pulse: begin issuing from slot 0
clear  input  1  one-cycle pulse: empty the buffer and return to IDLE
gap_cycles  input  GAP_W  NOP cycles inserted after each issued instruction; sampled at start
instr  output  INSTR_W  instruction to the PSIMD core
instr_valid  output  1  instr holds a real program word this cycle
busy  output  1  state is ISSUE or GAP
done  output  1  program completed; held until the next start or clear
prog_count  output  $clog2(DEPTH)+1  number of words loaded
invalid_acc, inexact_acc, overflow_acc, underflow_acc, div_by_zero_acc  output  4 each  sticky per-lane OR of the core flags
invalid, inexact, overflow, underflow, div_by_zero  input  4 each  core flag outputs

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; prog_count=0; read pointer=0; instr=NOP_INSTR; instr_valid=0; busy=0; done=0; all *_acc=0. Buffer contents are don't-care.
- load_ready = 1 only in IDLE or DONE with prog_count<DEPTH.
  - load_valid&&load_ready writes slot[prog_count] and increments prog_count.
  - A load in DONE clears done.
- FSM states: IDLE, ISSUE, GAP, DONE.
- IDLE/DONE + start:
  - With prog_count==0: go to DONE, done=1 the next cycle, no issue.
  - Otherwise: latch gap_cycles, reset the read pointer to 0, clear all *_acc and done, go to ISSUE.
- ISSUE, one cycle per word:
  - Drive instr=slot[ptr] combinationally from registered ptr, with instr_valid=1, then increment ptr.
  - If ptr was prog_count-1: go to DONE.
  - Else if the latched gap is non-zero: go to GAP with the gap counter set to gap.
  - Else: stay in ISSUE.
- GAP: instr=NOP_INSTR, instr_valid=0; the counter decrements each cycle; return to ISSUE when it reaches 1.
- Latency from start (cycle 0) to first instr_valid: cycle 1.
  - Total issue window = N + (N-1)*gap cycles. No gap follows the last word.
  - done rises the cycle after the last instr_valid.
- Flag collection: the core flags are combinational from instr. On every cycle with instr_valid=1, each *_acc |= its flag input. Flags on invalid cycles are ignored.
- start during ISSUE/GAP: ignored. load_valid outside IDLE/DONE: ignored (load_ready=0).
- clear in any state: prog_count=0, ptr=0, state IDLE, done=0, instr=NOP_INSTR; *_acc retained. clear has priority over a simultaneous start or load.
- The program is retained after DONE; a second start replays the same program.

Optional Feature:
PSIMD_ISSUE_PERF_EN
- Defined: adds output perf_cycles [15:0]. It clears on an accepted start, increments each cycle in ISSUE or GAP, saturates at 16'hFFFF, and holds in DONE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package psimd_issue_pkg: issuer_state_e enum (IDLE, ISSUE, GAP, DONE), FLAG_W=4 lane constant, default NOP constant.
- Sub-module psimd_instr_buf: DEPTH x INSTR_W storage, write pointer/count, asynchronous read by pointer.
- The FSM, gap counter and flag accumulators stay in psimd_instr_issuer.

Test Plan:
1. Load 3 words A,B,C with gap_cycles=0, pulse start at cycle 0 -> instr=A,B,C with instr_valid=1 at cycles 1-3; done=1 at cycle 4; busy=1 at cycles 1-3.
2. Same program with gap_cycles=2 -> valid/NOP pattern A,N,N,B,N,N,C; done at cycle 8; instr=NOP_INSTR on the gap cycles.
3. Load 16 words -> load_ready=0 at prog_count=16. A 17th load_valid is dropped, and start issues exactly 16 words.
4. Drive invalid=4'b0010 only during B's cycle and overflow=4'b1000 during a gap cycle -> invalid_acc=4'b0010 and overflow_acc=0 at done. A second start clears both to 0 before issuing.
5. start with prog_count=0 -> no instr_valid; done=1 one cycle later.
6. clear asserted mid-GAP -> next cycle state IDLE, instr=NOP_INSTR, prog_count=0. Assert rst_n=0 mid-ISSUE -> all outputs return to their reset values at the next edge.
